// File: rtl/rom_access_ctrl.sv
// rom_access_ctrl: round-robin arbiter and access sequencer for a slow
// asynchronous 32-bit ROM shared by two synchronous requesters.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/addr0          requester 0 read request and byte address
//   req1/addr1          requester 1 read request and byte address
//   ack0/ack1           one-cycle completion pulse per requester
//   rdata/err           shared read data / out-of-range flag, valid with ack
//   busy                high while a transaction is in flight
//   rom_a/rom_d         ROM byte address out, ROM data in
`timescale 1ns/1ps
module rom_access_ctrl #(
    parameter int WAIT_CYCLES = 10,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic        req1,
    input  logic [31:0] addr1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [31:0] rom_a,
    input  logic [31:0] rom_d
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [31:0]   DEPTH_32 = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          gid_q, gid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rom_a_q, rom_a_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;

    logic          grant_v;
    logic          grant_id;
    logic [31:0]   g_addr;
    logic          in_range;

    always_comb begin
        grant_v  = req0 | req1;
        // Contention goes to the pointer; otherwise whoever is asking.
        grant_id = (req0 & req1) ? ptr_q : req1;
        g_addr   = grant_id ? addr1 : addr0;
        // Full 30-bit word index compare so large addresses never alias.
        in_range = ({2'b00, g_addr[31:2]} < DEPTH_32);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        rom_a_d = rom_a_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_v) begin
                    gid_d = grant_id;
                    if (in_range) begin
                        rom_a_d = {g_addr[31:2], 2'b00};
                        cnt_d   = CNT_LOAD;
                        state_d = S_WAIT;
                    end else begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rdata_d = rom_d;
                    err_d   = 1'b0;
                    ack0_d  = ~gid_q;
                    ack1_d  = gid_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // Entry from WAIT already raised ack; an out-of-range
                // entry raises it here, one cycle after the grant edge.
                if (ack0_q | ack1_q) begin
                    ptr_d   = ~gid_q;
                    state_d = S_IDLE;
                end else begin
                    ack0_d = ~gid_q;
                    ack1_d = gid_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            gid_q   <= 1'b0;
            cnt_q   <= '0;
            rom_a_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            rom_a_q <= rom_a_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign busy  = busy_q;
    assign rom_a = rom_a_q;

endmodule
